dac_sample_feeder: RTL and testbench

Paced sample source that sits directly upstream of the serial DAC driver. It buffers 16-bit DAC codes written by the user side in a small synchronous FIFO and issues them to the DAC driver's `din`/`din_vld`/`rdy` port at a fixed update rate derived from the system clock. Missed or late update slots are flagged with sticky status bits. All logic runs in one clock domain.

---
 rtl/dac_sample_feeder.sv | 114 +++++++++++
 tb/tb_dac_sample_feeder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_sample_feeder.sv
// rtl/dac_sample_feeder.sv - paced FIFO sample source feeding the serial DAC driver
module dac_sample_feeder #(
    parameter int DEPTH_LOG2 = 4,
    parameter int RATE_DIV   = 200
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [15:0]           wr_data,
    input  logic                  wr_en,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   level,
    output logic [15:0]           dac_din,
    output logic                  dac_din_vld,
    input  logic                  dac_rdy,
    input  logic                  clr_err,
    output logic                  underflow,
    output logic                  late,
    output logic                  overflow
);

    localparam int                  DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] LEVEL_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
    localparam logic [15:0]         CNT_LAST   = 16'(RATE_DIV - 1);

    logic [15:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [15:0]           cnt;
    logic                  pending;
    logic                  tick;
    logic                  req;
    logic                  push;
    logic                  issue;
    logic                  skip;
    logic                  busy;
    logic [DEPTH_LOG2:0]   level_nxt;

    always_comb begin
        tick  = en && (cnt == CNT_LAST);
        req   = tick || pending;
        // full is the registered pre-edge value, so a write racing a pop on a full FIFO is rejected
        push  = wr_en && !full;
        issue = req && (level != '0) && dac_rdy && !dac_din_vld;
        skip  = req && (level == '0);
        busy  = req && !issue && !skip;
        level_nxt = level;
        if (push && !issue) begin
            level_nxt = level + LEVEL_ONE;
        end else if (issue && !push) begin
            level_nxt = level - LEVEL_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!en || cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            full        <= 1'b0;
            dac_din     <= '0;
            dac_din_vld <= 1'b0;
            pending     <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (issue) begin
                rd_ptr  <= rd_ptr + PTR_ONE;
                dac_din <= mem[rd_ptr];
            end
            dac_din_vld <= issue;
            level       <= level_nxt;
            full        <= (level_nxt == LEVEL_FULL);
            // at most one slot is ever outstanding; a busy DAC keeps it armed until rdy
            if (!en || issue || skip) begin
                pending <= 1'b0;
            end else if (busy) begin
                pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underflow <= 1'b0;
            late      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            underflow <= skip | (underflow & ~clr_err);
            late      <= (tick & pending & ~issue) | (late & ~clr_err);
            overflow  <= (wr_en & full) | (overflow & ~clr_err);
        end
    end

endmodule

// File: tb/tb_dac_sample_feeder.sv
// tb/tb_dac_sample_feeder.sv - scoreboard bench for dac_sample_feeder
module tb_dac_sample_feeder;

    localparam int DL = 4;
    localparam int RD = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [15:0]   wr_data;
    logic          wr_en;
    logic          full;
    logic [DL:0]   level;
    logic [15:0]   dac_din;
    logic          dac_din_vld;
    logic          dac_rdy;
    logic          clr_err;
    logic          underflow;
    logic          late;
    logic          overflow;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [15:0]   exp_q[$];
    logic          prev_vld = 1'b0;
    int            cyc;
    logic          seen;

    dac_sample_feeder #(.DEPTH_LOG2(DL), .RATE_DIV(RD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .wr_data    (wr_data),
        .wr_en      (wr_en),
        .full       (full),
        .level      (level),
        .dac_din    (dac_din),
        .dac_din_vld(dac_din_vld),
        .dac_rdy    (dac_rdy),
        .clr_err    (clr_err),
        .underflow  (underflow),
        .late       (late),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [15:0] d);
        wr_data = d;
        wr_en   = 1'b1;
        if (exp_q.size() < (1 << DL)) exp_q.push_back(d);
        step(1);
        wr_en = 1'b0;
    endtask

    task automatic reset_dut();
        rst_n   = 1'b0;
        en      = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        clr_err = 1'b0;
        dac_rdy = 1'b1;
        exp_q.delete();
        step(2);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0) break;
            step(1);
        end
        check("drain_empty", 32'(exp_q.size()), 0);
    endtask

    // every issue is scored against the oldest accepted write
    always @(negedge clk) begin
        if (rst_n && dac_din_vld) begin
            check("vld_gap", 32'(prev_vld), 0);
            if (exp_q.size() == 0) check("vld_spurious", 1, 0);
            else check("din", 32'(dac_din), 32'(exp_q.pop_front()));
        end
        prev_vld = rst_n && dac_din_vld;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_dut();
        check("rst_level", 32'(level), 0);
        check("rst_full", 32'(full), 0);
        check("rst_out", 32'({dac_din, dac_din_vld}), 0);
        check("rst_flags", 32'({underflow, late, overflow}), 0);

        // steady pacing
        wr('h1234);
        wr('hABCD);
        wr('h0001);
        en = 1'b1;
        cyc = 1;
        repeat (25) begin
            step(1);
            cyc++;
            check("t1_vld", 32'(dac_din_vld), 32'(cyc == 9 || cyc == 17 || cyc == 25));
            if (cyc == 10) check("t1_hold", 32'(dac_din), 'h1234);
        end
        check("t1_level", 32'(level), 0);
        check("t1_flags", 32'({underflow, late, overflow}), 0);

        // underflow
        reset_dut();
        wr('h5555);
        en = 1'b1;
        cyc = 1;
        repeat (17) begin
            step(1);
            cyc++;
            check("t2_vld", 32'(dac_din_vld), 32'(cyc == 9));
            check("t2_uf", 32'(underflow), 32'(cyc >= 17));
        end
        en = 1'b0;
        clr_err = 1'b1;
        step(1);
        clr_err = 1'b0;
        check("t2_clr", 32'(underflow), 0);

        // busy DAC and late
        reset_dut();
        dac_rdy = 1'b0;
        for (int i = 0; i < 4; i++) wr(16'(16'h2000 + i));
        en = 1'b1;
        cyc = 1;
        repeat (19) begin
            step(1);
            cyc++;
            check("t3_vld_busy", 32'(dac_din_vld), 0);
            check("t3_late", 32'(late), 32'(cyc >= 17));
        end
        dac_rdy = 1'b1;
        repeat (3) begin
            step(1);
            cyc++;
            check("t3_vld_rdy", 32'(dac_din_vld), 32'(cyc == 21));
        end
        check("t3_uf", 32'(underflow), 0);

        // full and overflow
        reset_dut();
        for (int i = 0; i < 17; i++) begin
            wr(16'(16'h0100 * i + 7));
            if (i == 14) begin
                check("t4_lvl15", 32'(level), 15);
                check("t4_full15", 32'(full), 0);
            end
            if (i == 15) begin
                check("t4_lvl16", 32'(level), 16);
                check("t4_full16", 32'(full), 1);
                check("t4_ovf16", 32'(overflow), 0);
            end
        end
        check("t4_lvl17", 32'(level), 16);
        check("t4_ovf17", 32'(overflow), 1);
        clr_err = 1'b1;
        step(1);
        clr_err = 1'b0;
        check("t4_ovf_clr", 32'(overflow), 0);
        en = 1'b1;
        step(7);
        wr('hDEAD);
        check("t4_pop_lvl", 32'(level), 15);
        check("t4_pop_full", 32'(full), 0);
        check("t4_pop_ovf", 32'(overflow), 1);
        check("t4_pop_vld", 32'(dac_din_vld), 1);
        drain();
        check("t4_end_lvl", 32'(level), 0);

        // reset mid-operation
        reset_dut();
        for (int i = 0; i < 5; i++) wr(16'(16'h3000 + i));
        en = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step(1);
            seen = dac_din_vld;
        end
        check("t5_vld_seen", 32'(seen), 1);
        step(1);
        rst_n = 1'b0;
        en = 1'b0;
        #1;
        check("t5_rst_out", 32'({dac_din, dac_din_vld}), 0);
        check("t5_rst_fifo", 32'({level, full}), 0);
        check("t5_rst_flags", 32'({underflow, late, overflow}), 0);
        exp_q.delete();
        step(2);
        rst_n = 1'b1;
        en = 1'b1;
        cyc = 1;
        repeat (8) begin
            step(1);
            cyc++;
            check("t5_vld", 32'(dac_din_vld), 0);
            check("t5_uf", 32'(underflow), 32'(cyc >= 9));
        end

        // enable toggle while a slot is pending
        reset_dut();
        for (int i = 0; i < 3; i++) wr(16'(16'h4A00 + i));
        dac_rdy = 1'b0;
        en = 1'b1;
        step(8);
        check("t6_vld_busy", 32'(dac_din_vld), 0);
        en = 1'b0;
        step(1);
        en = 1'b1;
        dac_rdy = 1'b1;
        cyc = 1;
        repeat (9) begin
            step(1);
            cyc++;
            check("t6_vld", 32'(dac_din_vld), 32'(cyc == 9));
        end
        drain();
        en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
